// File: rtl/row_clear_scanner.sv
`default_nettype none
// ============================================================================
// Module   : row_clear_scanner
// Brief    : Scans playfield rows bottom-up after a piece lands, finds groups
//            of up to four adjacent full rows, requests their clearing
//            synchronised to the vertical-sync falling edge, waits for the
//            playfield to settle and rescans until no full row remains.
//            Optional macro ROW_CLEAR_SCORE_EN enables the score accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module row_clear_scanner #(
    parameter int          ROWS       = 20,
    parameter logic [15:0] BG_COLOR   = 16'h000F,
    parameter int          CLEAR_WAIT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_start,
    input  logic              vs,
    input  logic              row_ready,
    input  logic [9:0][15:0]  read_reg,
    output logic              row_ld,
    output logic [7:0]        row,
    output logic              clear_the_row_ho,
    output logic [7:0]        clear_row,
    output logic [7:0]        clear_num_rows,
    output logic              busy,
    output logic              scan_done,
    output logic [4:0]        lines_cleared,
    output logic [15:0]       score
);

    localparam int          c_settle_w   = (CLEAR_WAIT > 1) ? $clog2(CLEAR_WAIT) : 1;
    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(CLEAR_WAIT - 1);
    localparam logic [7:0]  c_top_row    = 8'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_EVAL   = 3'd3,
        S_CLEAR  = 3'd4,
        S_SETTLE = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              row_q, row_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [7:0]              bottom_q, bottom_d;
    logic                    full_q, full_d;
    logic [7:0]              clear_row_q, clear_row_d;
    logic [7:0]              clear_num_q, clear_num_d;
    logic [4:0]              lines_q, lines_d;
    logic                    vs_seen_q, vs_seen_d;
    logic [c_settle_w-1:0]   settle_q, settle_d;
    logic                    row_ld_q, clear_ho_q, busy_q, scan_done_q;

    logic                    w_row_full;
    logic                    w_enter_clear;
    logic [2:0]              w_clr_cnt;
    logic [7:0]              w_clr_bottom;
    logic [5:0]              w_lines_sum;

    // A row is full only when no column holds the background value
    always_comb begin
        w_row_full = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (read_reg[c] == BG_COLOR) begin
                w_row_full = 1'b0;
            end
        end
    end

    // Next-state and datapath logic for the scan / clear / settle sequence
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        cnt_d         = cnt_q;
        bottom_d      = bottom_q;
        full_d        = full_q;
        clear_row_d   = clear_row_q;
        clear_num_d   = clear_num_q;
        lines_d       = lines_q;
        vs_seen_d     = vs_seen_q;
        settle_d      = settle_q;
        w_enter_clear = 1'b0;
        w_clr_cnt     = cnt_q;
        w_clr_bottom  = bottom_q;
        w_lines_sum   = 6'd0;

        case (state_q)
            S_IDLE: begin
                if (scan_start) begin
                    row_d   = c_top_row;
                    cnt_d   = 3'd0;
                    lines_d = 5'd0;
                    state_d = S_REQ;
                end
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                if (row_ready) begin
                    full_d  = w_row_full;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (full_q) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd0) begin
                        bottom_d = row_q;
                    end
                    if ((cnt_d == 3'd4) || (row_q == 8'd0)) begin
                        w_enter_clear = 1'b1;
                        w_clr_cnt     = cnt_d;
                        w_clr_bottom  = (cnt_q == 3'd0) ? row_q : bottom_q;
                    end else begin
                        row_d   = row_q - 8'd1;
                        state_d = S_REQ;
                    end
                end else if (cnt_q != 3'd0) begin
                    w_enter_clear = 1'b1;
                end else if (row_q == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    row_d   = row_q - 8'd1;
                    state_d = S_REQ;
                end
            end
            S_CLEAR: begin
                // Release only on a falling edge that follows a seen-high vs
                if (vs_seen_q && !vs) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                end else if (vs) begin
                    vs_seen_d = 1'b1;
                end
            end
            S_SETTLE: begin
                if (settle_q == c_settle_last) begin
                    cnt_d   = 3'd0;
                    row_d   = c_top_row;
                    state_d = S_REQ;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Group results are captured once, at the transition into CLEAR
        if (w_enter_clear) begin
            state_d     = S_CLEAR;
            clear_row_d = w_clr_bottom;
            clear_num_d = {5'd0, w_clr_cnt};
            w_lines_sum = {1'b0, lines_q} + {3'd0, w_clr_cnt};
            lines_d     = (w_lines_sum > 6'd31) ? 5'd31 : w_lines_sum[4:0];
            vs_seen_d   = vs;
        end
    end

    // State and datapath registers; outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            row_q       <= 8'd0;
            cnt_q       <= 3'd0;
            bottom_q    <= 8'd0;
            full_q      <= 1'b0;
            clear_row_q <= 8'd0;
            clear_num_q <= 8'd0;
            lines_q     <= 5'd0;
            vs_seen_q   <= 1'b0;
            settle_q    <= '0;
            row_ld_q    <= 1'b0;
            clear_ho_q  <= 1'b0;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            bottom_q    <= bottom_d;
            full_q      <= full_d;
            clear_row_q <= clear_row_d;
            clear_num_q <= clear_num_d;
            lines_q     <= lines_d;
            vs_seen_q   <= vs_seen_d;
            settle_q    <= settle_d;
            row_ld_q    <= (state_d == S_REQ);
            clear_ho_q  <= (state_d == S_CLEAR);
            busy_q      <= (state_d != S_IDLE);
            scan_done_q <= (state_d == S_DONE);
        end
    end

`ifdef ROW_CLEAR_SCORE_EN
    logic [15:0] score_q, score_d;
    logic [15:0] w_score_inc;
    logic [16:0] w_score_sum;

    // Line-clear points by group size, saturating at the 16-bit maximum
    always_comb begin
        case (w_clr_cnt)
            3'd1:    w_score_inc = 16'd40;
            3'd2:    w_score_inc = 16'd100;
            3'd3:    w_score_inc = 16'd300;
            3'd4:    w_score_inc = 16'd1200;
            default: w_score_inc = 16'd0;
        endcase
        w_score_sum = {1'b0, score_q} + {1'b0, w_score_inc};
        score_d     = score_q;
        if (w_enter_clear) begin
            score_d = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        end
    end

    // Score accumulator register
    always_ff @(posedge clk) begin
        if (reset) begin
            score_q <= 16'd0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`else
    assign score = 16'h0000;
`endif

    assign row_ld           = row_ld_q;
    assign row              = row_q;
    assign clear_the_row_ho = clear_ho_q;
    assign clear_row        = clear_row_q;
    assign clear_num_rows   = clear_num_q;
    assign busy             = busy_q;
    assign scan_done        = scan_done_q;
    assign lines_cleared    = lines_q;

endmodule
`default_nettype wire

// File: doc/row_clear_scanner.md
ROW_CLEAR_SCANNER -- requirements
Module: row_clear_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 20: playfield row count; rows numbered 0 (top) to ROWS-1 (bottom).
REQ-002 SHALL have parameter BG_COLOR, default 16'h000F: background cell value; any other value marks the cell occupied.
REQ-003 SHALL have parameter CLEAR_WAIT, default 1024: settle cycles after a clear before rescanning.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 scan_start  input  1  one-cycle pulse: piece landed, start scan.
REQ-008 vs  input  1  vertical sync level.
REQ-009 row_ready  input  1  row read complete; read_reg valid this cycle.
REQ-010 read_reg  input  16 x 10  cell values of the requested row, column 0..9.
REQ-011 row_ld  output  1  one-cycle row read request.
REQ-012 row  output  8  row index being requested.
REQ-013 clear_the_row_ho  output  1  clear request level.
REQ-014 clear_row  output  8  bottom row of the group being cleared.
REQ-015 clear_num_rows  output  8  rows in the group, 1..4.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 scan_done  output  1  one-cycle pulse at end of scan.
REQ-018 lines_cleared  output  5  rows cleared during the last scan, saturating at 31.
REQ-019 score  output  16  accumulated score (see Configuration).

Function
REQ-020 States SHALL be IDLE, REQ, WAIT, EVAL, CLEAR, SETTLE, DONE.
REQ-021 IDLE: scan_start SHALL set row=ROWS-1, group count 0, lines_cleared 0, next REQ; scan_start outside IDLE SHALL be ignored.
REQ-022 REQ: row_ld SHALL be high exactly one cycle, then WAIT.
REQ-023 WAIT: SHALL hold until row_ready=1; in that cycle a registered full flag SHALL capture (all 10 read_reg entries != BG_COLOR); next EVAL.
REQ-024 EVAL, full row: group count SHALL increment; group bottom row SHALL latch on the first full row of a group; if group count reaches 4 or row==0 go CLEAR, else row decrements and go REQ.
REQ-025 EVAL, not full: group count >0 SHALL go CLEAR; else row==0 SHALL go DONE; else row decrements and go REQ.
REQ-026 On CLEAR entry clear_row and clear_num_rows SHALL load the group bottom row and count, and lines_cleared SHALL add the count (saturating).
REQ-027 CLEAR: clear_the_row_ho SHALL be high; SHALL deassert and go SETTLE on the first vs falling edge after vs has been seen high in CLEAR; vs already high on entry counts as seen.
REQ-028 SETTLE: SHALL count CLEAR_WAIT cycles, then reset group count, set row=ROWS-1, go REQ (full rescan).
REQ-029 DONE: scan_done SHALL be high one cycle, then IDLE.
REQ-030 A row with any BG_COLOR cell SHALL never be counted; row SHALL never underflow below 0.

Reset
REQ-031 On reset the state SHALL be IDLE; row_ld, clear_the_row_ho, busy, scan_done = 0; row, clear_row, clear_num_rows = 0; lines_cleared = 0; score = 0; counters 0.
REQ-032 Reset mid-operation SHALL abort within one cycle with all outputs at reset values; no partial clear request SHALL remain.

Configuration
REQ-033 Macro ROW_CLEAR_SCORE_EN defined: on CLEAR entry score SHALL add 40/100/300/1200 for group count 1/2/3/4, saturating at 16'hFFFF.
REQ-034 Macro ROW_CLEAR_SCORE_EN undefined: score SHALL be constant 0 and no score logic SHALL be synthesized.

Verification
REQ-035 All rows empty, scan_start -> 20 row_ld pulses, rows 19..0, scan_done, lines_cleared=0, clear_the_row_ho never high.
REQ-036 Row 19 full only -> clear_row=19, clear_num_rows=1 held until vs fall; after CLEAR_WAIT rescan from 19; lines_cleared=1, score=40 with macro.
REQ-037 Rows 16..19 full -> single clear, clear_row=19, clear_num_rows=4, score=1200 with macro, 0 without.
REQ-038 Row 19 full with read_reg[9]=16'h000F -> no clear; row 18 requested next.
REQ-039 Reset asserted in CLEAR -> next cycle clear_the_row_ho=0, busy=0, state IDLE; scan_start pulse while busy ignored.
REQ-040 Rows 18,19 full and row 5 full -> two CLEAR passes (19/2, then after rescan the shifted row) and lines_cleared=3.
